// File: rtl/fp_operand_unpack_if.sv
// fp_operand_unpack_if: operand-pair handshake and unpacked result bundle
interface fp_operand_unpack_if #(parameter int EXP_W = 10);
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      op_A;
  logic [31:0]      op_B;
  logic             out_valid;
  logic             out_ready;
  logic             sign_A;
  logic             sign_B;
  logic [7:0]       exp_A;
  logic [7:0]       exp_B;
  logic [22:0]      mantis_A;
  logic [22:0]      mantis_B;
  logic [2:0]       type_A;
  logic [2:0]       type_B;
  logic [EXP_W-1:0] norm_exp_A;
  logic [EXP_W-1:0] norm_exp_B;
  logic [23:0]      norm_sig_A;
  logic [23:0]      norm_sig_B;
  modport master (
    output in_valid, op_A, op_B, out_ready,
    input  in_ready, out_valid, sign_A, sign_B, exp_A, exp_B, mantis_A, mantis_B,
           type_A, type_B, norm_exp_A, norm_exp_B, norm_sig_A, norm_sig_B
  );
  modport slave (
    input  in_valid, op_A, op_B, out_ready,
    output in_ready, out_valid, sign_A, sign_B, exp_A, exp_B, mantis_A, mantis_B,
           type_A, type_B, norm_exp_A, norm_exp_B, norm_sig_A, norm_sig_B
  );
endinterface

// File: rtl/fp_operand_unpack.sv
// fp_operand_unpack: splits, classifies and normalizes an IEEE-754 binary32 operand pair
module fp_operand_unpack #(parameter int EXP_W = 10) (
  input logic clk,
  input logic rst,
  fp_operand_unpack_if.slave bus_io
);
  localparam logic [2:0] T_ZERO = 3'b000, T_INF = 3'b001, T_SUB = 3'b010, T_NORM = 3'b011, T_NAN = 3'b100;
  typedef enum logic [1:0] {IDLE, NORM, HOLD} state_t;
  state_t           state_q, state_d;
  logic [31:0]      op     [2];
  logic [2:0]       cls    [2];
  logic             sign_q [2], sign_d [2];
  logic [7:0]       exp_q  [2], exp_d  [2];
  logic [22:0]      man_q  [2], man_d  [2];
  logic [2:0]       type_q [2], type_d [2];
  logic [EXP_W-1:0] nexp_q [2], nexp_d [2];
  logic [23:0]      nsig_q [2], nsig_d [2];
  logic             cap, any_sub, all_done;

  function automatic logic [2:0] classify(input logic [31:0] x);
    return x[30:23] == 8'h00 ? (x[22:0] == '0 ? T_ZERO : T_SUB) :
           x[30:23] == 8'hFF ? (x[22:0] == '0 ? T_INF : T_NAN) : T_NORM;
  endfunction

  assign op[0]  = bus_io.op_A;
  assign op[1]  = bus_io.op_B;
  assign cls[0] = classify(op[0]);
  assign cls[1] = classify(op[1]);

  assign bus_io.in_ready  = !rst && (state_q == IDLE || (state_q == HOLD && bus_io.out_ready));
  assign bus_io.out_valid = !rst && state_q == HOLD;
  assign cap      = bus_io.in_valid && bus_io.in_ready;
  assign any_sub  = cls[0] == T_SUB || cls[1] == T_SUB;
  assign all_done = (type_q[0] != T_SUB || nsig_q[0][23] || nsig_q[0][22]) &&
                    (type_q[1] != T_SUB || nsig_q[1][23] || nsig_q[1][22]);

  // Control: capture from IDLE/HOLD, shift in NORM until both leading ones land, hold until accepted
  always_comb begin
    state_d = state_q;
    if (cap)
      state_d = any_sub ? NORM : HOLD;
    else if (state_q == NORM && all_done)
      state_d = HOLD;
    else if (state_q == HOLD && bus_io.out_ready)
      state_d = IDLE;
  end

  // Datapath: load fields and initial normalized values on capture, shift unnormalized subnormals in NORM
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      sign_d[i] = sign_q[i];
      exp_d[i]  = exp_q[i];
      man_d[i]  = man_q[i];
      type_d[i] = type_q[i];
      nexp_d[i] = nexp_q[i];
      nsig_d[i] = nsig_q[i];
      if (cap) begin
        sign_d[i] = op[i][31];
        exp_d[i]  = op[i][30:23];
        man_d[i]  = op[i][22:0];
        type_d[i] = cls[i];
        nsig_d[i] = cls[i] == T_ZERO ? '0 : {cls[i] == T_NORM, op[i][22:0]};
        nexp_d[i] = cls[i] == T_NORM ? EXP_W'(op[i][30:23]) - EXP_W'(127) :
                    cls[i] == T_SUB  ? -EXP_W'(126) :
                    cls[i] == T_ZERO ? '0 : EXP_W'(128);
      end else if (state_q == NORM && type_q[i] == T_SUB && !nsig_q[i][23]) begin
        nsig_d[i] = nsig_q[i] << 1;
        nexp_d[i] = nexp_q[i] - EXP_W'(1);
      end
    end
  end

  // State and output registers, cleared by reset so an interrupted operation never surfaces
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      for (int i = 0; i < 2; i++) begin
        sign_q[i] <= '0;
        exp_q[i]  <= '0;
        man_q[i]  <= '0;
        type_q[i] <= '0;
        nexp_q[i] <= '0;
        nsig_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      for (int i = 0; i < 2; i++) begin
        sign_q[i] <= sign_d[i];
        exp_q[i]  <= exp_d[i];
        man_q[i]  <= man_d[i];
        type_q[i] <= type_d[i];
        nexp_q[i] <= nexp_d[i];
        nsig_q[i] <= nsig_d[i];
      end
    end
  end

  assign bus_io.sign_A     = sign_q[0];
  assign bus_io.sign_B     = sign_q[1];
  assign bus_io.exp_A      = exp_q[0];
  assign bus_io.exp_B      = exp_q[1];
  assign bus_io.mantis_A   = man_q[0];
  assign bus_io.mantis_B   = man_q[1];
  assign bus_io.type_A     = type_q[0];
  assign bus_io.type_B     = type_q[1];
  assign bus_io.norm_exp_A = nexp_q[0];
  assign bus_io.norm_exp_B = nexp_q[1];
  assign bus_io.norm_sig_A = nsig_q[0];
  assign bus_io.norm_sig_B = nsig_q[1];
endmodule

// File: doc/fp_operand_unpack.md
Name: fp_operand_unpack

Overview:
- Front-end stage of the FP adder. Accepts a pair of IEEE-754 single-precision operands over a valid/ready handshake.
- Splits each operand into sign, exponent and mantissa fields and classifies it with the adder's type encoding.
- Produces a normalized significand and unbiased exponent for each operand. Subnormals are normalized by a multi-cycle shift FSM.
- Raw fields and types feed the special-case resolver. The normalized fields feed the align/add datapath.

Parameters:
- EXP_W, 10, width of signed unbiased exponent outputs (two's complement).

Ports:
- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  block can accept operand pair
- op_A  input  32  operand A, IEEE-754 binary32
- op_B  input  32  operand B, IEEE-754 binary32
- out_valid  output  1  unpacked result valid
- out_ready  input  1  downstream accepts result
- sign_A, sign_B  output  1 each  captured sign bits
- exp_A, exp_B  output  8 each  captured biased exponent fields
- mantis_A, mantis_B  output  23 each  captured fraction fields
- type_A, type_B  output  3 each  class code
- norm_exp_A, norm_exp_B  output  EXP_W each  signed unbiased exponent after normalization
- norm_sig_A, norm_sig_B  output  24 each  normalized significand, bit 23 = leading one

Behaviour:
- Type codes: ZERO=000, INF=001, SUBNORMAL=010, NORMAL=011, NAN=100.
- Classification per operand:
  - exp=00, frac=0 -> ZERO
  - exp=00, frac!=0 -> SUBNORMAL
  - exp=FF, frac=0 -> INF
  - exp=FF, frac!=0 -> NAN
  - otherwise NORMAL
- Initial normalized values at capture:
  - NORMAL: sig={1,frac}, exp=biased-127
  - SUBNORMAL: sig={0,frac}, exp=-126
  - ZERO: sig=0, exp=0
  - INF/NAN: sig={0,frac}, exp=+128
- FSM states: IDLE, NORM, HOLD.
- IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid, capture both operands and all raw fields and types.
  - Go to NORM if either operand is SUBNORMAL, else go to HOLD.
- NORM:
  - in_ready=0, out_valid=0.
  - Each cycle, every SUBNORMAL operand whose sig[23]==0 shifts sig left 1 and decrements exp by 1. Operands already normalized hold.
  - Leave for HOLD on the edge at which every SUBNORMAL operand's post-update sig[23] is 1.
  - Raw fields and types are not modified.
- HOLD:
  - out_valid=1. All outputs are stable until accepted.
  - in_ready=out_ready, which allows back-to-back transfers.
  - out_ready&in_valid: accept the result and capture the new pair in the same edge. Next state follows the IDLE rules.
  - out_ready&!in_valid: go to IDLE.
  - !out_ready: stay in HOLD.
- Latency from capture edge:
  - No subnormal: out_valid high in the next cycle.
  - Otherwise: S extra cycles, where S = max over subnormal operands of (23-k) and k = index of the highest set fraction bit. Range is 1..23.
- Throughput: one pair per cycle when neither operand is subnormal and out_ready is held high.
- Exponent arithmetic is signed EXP_W bits. The minimum value is -149 (frac=0x000001), so overflow is impossible.
- Reset:
  - state=IDLE, out_valid=0, in_ready=0 while rst is high.
  - All field, type and normalized outputs are 0.
  - rst mid-NORM or mid-HOLD discards the operation, and no result is emitted.
- in_valid while in_ready=0 is ignored. op_A and op_B are don't-care then.
- Output registers change only on a capture or NORM shift edge, never while out_valid&!out_ready.

Test Plan:
- Normal pair: A=0x3F800000, B=0xC0000000 -> out_valid 1 cycle after capture.
  - type_A=011, norm_exp_A=0, norm_sig_A=0x800000
  - type_B=011, sign_B=1, norm_exp_B=1, norm_sig_B=0x800000
- Deepest subnormal: A=0x00000001, B=0x3F800000 -> out_valid after 23 extra cycles.
  - type_A=010, norm_sig_A=0x800000, norm_exp_A=-149 (10'h36B)
  - raw mantis_A=0x000001
  - B unchanged
- Two subnormals: A=0x00400000, B=0x00000100 -> S=15.
  - norm_exp_A=-127, norm_exp_B=-141, both sig=0x800000
  - A stops shifting after 1 cycle
- Specials: A=0x7F800000, B=0x7FC00001 -> type_A=001, type_B=100, 1-cycle latency. A=0x80000000 -> type ZERO, sign 1, sig 0.
- Backpressure/back-to-back: hold out_ready=0 for 5 cycles in HOLD -> outputs stable, in_ready=0. Then out_ready=1 with in_valid=1 -> new pair captured on the same edge, with out_valid high on consecutive cycles and no bubble.
- Reset mid-NORM: A=0x00000001 captured, rst asserted at shift 10 -> out_valid=0, in_ready=0 during rst, all outputs 0. After rst drops: IDLE, in_ready=1, no stale result emitted.
